// File: rtl/key_press_conditioner.sv
// Pushbutton conditioner: two-flop synchronizer, debounce FSM, one-shot press
// pulse gated by en, debounced held level and a saturating press counter.
module key_press_conditioner #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic       en,
    output logic       press,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [8:0] DEB = 9'(DEBOUNCE);

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic [8:0] cnt_inc;
    logic       sync1, sync2, sync_hold, s;
    logic       stable, press_next, held_next;

    // The synchronizer stays released for one edge past reset so a key held
    // through reset is seen as a fresh press with a full debounce window.
    always_ff @(posedge clk) begin
        sync_hold <= reset;
        if (reset || sync_hold) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign s       = ~sync2;
    assign cnt_inc = {1'b0, cnt} + 9'd1;
    assign stable  = (cnt_inc >= DEB);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RELEASED;
            cnt         <= 8'd0;
            press       <= 1'b0;
            held        <= 1'b0;
            press_count <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            press <= press_next;
            held  <= held_next;
            if (press_next && press_count != 8'hFF)
                press_count <= press_count + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RELEASED: begin
                if (s) begin
                    if (DEBOUNCE == 1) begin
                        state_next = PRESSED;
                        cnt_next   = 8'd0;
                    end else begin
                        state_next = PRESS_WAIT;
                        cnt_next   = 8'd1;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_next = RELEASED;
                    cnt_next   = 8'd0;
                end else if (stable) begin
                    state_next = PRESSED;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt_inc[7:0];
                end
            end
            PRESSED: begin
                if (!s) begin
                    if (DEBOUNCE == 1) begin
                        state_next = RELEASED;
                        cnt_next   = 8'd0;
                    end else begin
                        state_next = RELEASE_WAIT;
                        cnt_next   = 8'd1;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_next = PRESSED;
                    cnt_next   = 8'd0;
                end else if (stable) begin
                    state_next = RELEASED;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt_inc[7:0];
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // A pulse only on a fresh entry into PRESSED; bounces back from RELEASE_WAIT are silent.
    always_comb begin
        press_next = en && (state_next == PRESSED) &&
                     (state == RELEASED || state == PRESS_WAIT);
        held_next  = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    end

endmodule

// File: tb/tb_key_press_conditioner.sv
// Scoreboard bench for key_press_conditioner (DEBOUNCE=4): stimulus pushes expected
// press/held events, a negedge monitor pops and compares them as the DUT emits them.
module tb_key_press_conditioner;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_n = 1'b1;
    logic       en = 1'b1;
    logic       press, held;
    logic [7:0] press_count;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    bit   mon_on = 1'b0;
    logic held_q = 1'b0;
    ev_t  pq[$];
    ev_t  hq[$];

    key_press_conditioner #(.DEBOUNCE(4)) dut (
        .clk(clk),
        .reset(reset),
        .key_n(key_n),
        .en(en),
        .press(press),
        .held(held),
        .press_count(press_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_press(input int at);
        ev_t e;
        if (exp_cnt < 255) exp_cnt++;
        e.cyc = at;
        e.val = 8'(exp_cnt);
        pq.push_back(e);
    endtask

    task automatic push_held(input int at, input logic v);
        ev_t e;
        e.cyc = at;
        e.val = {7'd0, v};
        hq.push_back(e);
    endtask

    // Key goes low at the next edge; press and held expected DEBOUNCE+1 edges later.
    task automatic press_key(input int n);
        int k;
        k = cyc + 1;
        push_held(k + 5, 1'b1);
        if (en) push_press(k + 5);
        key_n = 1'b0;
        run(n);
    endtask

    task automatic release_key(input int n);
        int j;
        j = cyc + 1;
        push_held(j + 5, 1'b0);
        key_n = 1'b1;
        run(n);
    endtask

    // Monitor: every press pulse and every held transition must match the next queued event.
    always @(negedge clk) begin
        if (mon_on) begin
            if (press === 1'b1) begin
                if (pq.size() == 0) begin
                    chk("press_unexpected", 1, 0);
                end else begin
                    ev_t e;
                    e = pq.pop_front();
                    chk("press_edge", cyc, e.cyc);
                    chk("press_count", int'(press_count), int'(e.val));
                end
            end
            if (held !== held_q) begin
                if (hq.size() == 0) begin
                    chk("held_unexpected", int'(held), int'(held_q));
                end else begin
                    ev_t e;
                    e = hq.pop_front();
                    chk("held_edge", cyc, e.cyc);
                    chk("held_value", int'(held), int'(e.val[0]));
                end
                held_q = held;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        run(3);
        chk("reset_press", int'(press), 0);
        chk("reset_held", int'(held), 0);
        chk("reset_count", int'(press_count), 0);
        reset = 1'b0;
        held_q = held;
        mon_on = 1'b1;
        run(5);

        // Clean press and release
        press_key(20);
        release_key(10);

        // Three-sample glitch then a real press
        key_n = 1'b0;
        run(3);
        key_n = 1'b1;
        run(1);
        press_key(10);
        release_key(10);

        // Release bounce while pressed: held stays, no new pulse
        press_key(10);
        key_n = 1'b1;
        run(2);
        key_n = 1'b0;
        run(5);
        release_key(10);

        // en=0 press/release, then en raised mid-hold
        en = 1'b0;
        press_key(10);
        release_key(10);
        press_key(8);
        en = 1'b1;
        run(5);
        release_key(10);
        chk("en_off_count", int'(press_count), exp_cnt);

        // Reset during PRESS_WAIT, key held through reset
        key_n = 1'b0;
        run(3);
        reset = 1'b1;
        run(1);
        chk("rst_pw_press", int'(press), 0);
        chk("rst_pw_held", int'(held), 0);
        chk("rst_pw_count", int'(press_count), 0);
        reset = 1'b0;
        exp_cnt = 0;
        push_held(cyc + 1 + 6, 1'b1);
        push_press(cyc + 1 + 6);
        run(10);

        // Reset during PRESSED, key still held
        reset = 1'b1;
        push_held(cyc + 1, 1'b0);
        run(1);
        chk("rst_p_press", int'(press), 0);
        chk("rst_p_held", int'(held), 0);
        chk("rst_p_count", int'(press_count), 0);
        reset = 1'b0;
        exp_cnt = 0;
        push_held(cyc + 1 + 6, 1'b1);
        push_press(cyc + 1 + 6);
        run(10);
        release_key(10);

        // Saturation: 300 clean presses
        for (int i = 0; i < 300; i++) begin
            press_key(6);
            release_key(6);
        end
        run(20);
        chk("sat_count", int'(press_count), 255);
        chk("press_queue_left", pq.size(), 0);
        chk("held_queue_left", hq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
